// File: rtl/tft_char_mover_if.sv
// Bundle of the frame-sync inputs and origin outputs between tft_ctrl,
// the character mover and the pixel generator.
interface tft_char_mover_if;
  logic       vsync;
  logic       run;
  logic [9:0] char_x0;
  logic [9:0] char_y0;
  logic       dir_x;
  logic       dir_y;
  logic       move_pulse;

  modport master (
    output vsync,
    output run,
    input  char_x0,
    input  char_y0,
    input  dir_x,
    input  dir_y,
    input  move_pulse
  );

  modport slave (
    input  vsync,
    input  run,
    output char_x0,
    output char_y0,
    output dir_x,
    output dir_y,
    output move_pulse
  );
endinterface

// File: rtl/tft_char_mover.sv
// Frame-synchronous bouncing origin for the character block.
// Define CHAR_MOVER_WRAP_EN to make the horizontal axis wrap instead of bounce.
module tft_char_mover #(
  parameter int H_VALID      = 480,
  parameter int V_VALID      = 272,
  parameter int CHAR_W       = 256,
  parameter int CHAR_H       = 32,
  parameter int STEP         = 2,
  parameter int FRAME_DIV    = 2,
  parameter int PAUSE_FRAMES = 30
) (
  input logic             tft_clk,
  input logic             sys_rst_n,
  tft_char_mover_if.slave bus
);

  localparam logic [10:0] X_MAX      = 11'(H_VALID - CHAR_W);
  localparam logic [10:0] Y_MAX      = 11'(V_VALID - CHAR_H);
  localparam logic [10:0] STEP_W     = 11'(STEP);
  localparam logic [15:0] FRAME_LAST = 16'(FRAME_DIV - 1);
  localparam logic [15:0] PAUSE_LAST = 16'(PAUSE_FRAMES - 1);
`ifdef CHAR_MOVER_WRAP_EN
  localparam logic WRAP_X = 1'b1;
`else
  localparam logic WRAP_X = 1'b0;
`endif

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic             v_d1_q, v_d2_q;
  logic             frame_tick;
  logic [15:0]      frame_cnt_q, frame_cnt_d;
  logic [15:0]      pause_cnt_q, pause_cnt_d;
  logic [1:0][9:0]  pos_q, pos_d, pos_mv;
  logic [1:0]       dir_q, dir_d, dir_mv;
  logic [1:0]       bounce;
  logic             move_pulse_q, move_pulse_d;

  assign frame_tick = v_d1_q & ~v_d2_q;

  // Index 0 is the horizontal axis, index 1 the vertical axis.
  genvar gi;
  for (gi = 0; gi < 2; gi++) begin : g_axis
    localparam logic [10:0] LIM  = (gi == 0) ? X_MAX : Y_MAX;
    localparam logic        WRAP = (gi == 0) ? WRAP_X : 1'b0;

    logic [10:0] sum;
    logic [9:0]  nxt_pos;
    logic        nxt_dir;
    logic        hit;

    assign sum = {1'b0, pos_q[gi]} + STEP_W;

    always_comb begin
      nxt_pos = pos_q[gi];
      nxt_dir = dir_q[gi];
      hit     = 1'b0;
      if (WRAP) begin
        nxt_dir = 1'b1;
        nxt_pos = (sum > LIM) ? 10'd0 : sum[9:0];
      end else if (dir_q[gi]) begin
        if (sum >= LIM) begin
          nxt_pos = LIM[9:0];
          nxt_dir = 1'b0;
          hit     = 1'b1;
        end else begin
          nxt_pos = sum[9:0];
        end
      end else if ({1'b0, pos_q[gi]} <= STEP_W) begin
        nxt_pos = 10'd0;
        nxt_dir = 1'b1;
        hit     = 1'b1;
      end else begin
        nxt_pos = pos_q[gi] - STEP_W[9:0];
      end
    end

    assign pos_mv[gi] = nxt_pos;
    assign dir_mv[gi] = nxt_dir;
    assign bounce[gi] = hit;
  end

  always_comb begin
    state_d      = state_q;
    frame_cnt_d  = frame_cnt_q;
    pause_cnt_d  = pause_cnt_q;
    pos_d        = pos_q;
    dir_d        = dir_q;
    move_pulse_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.run) begin
          state_d     = RUN;
          frame_cnt_d = '0;
        end
      end
      RUN: begin
        // run low wins over a coincident frame tick: no move is taken.
        if (!bus.run) begin
          state_d     = IDLE;
          frame_cnt_d = '0;
        end else if (frame_tick) begin
          if (frame_cnt_q == FRAME_LAST) begin
            frame_cnt_d  = '0;
            move_pulse_d = 1'b1;
            pos_d        = pos_mv;
            dir_d        = dir_mv;
            if (|bounce) begin
              state_d     = PAUSE;
              pause_cnt_d = '0;
            end
          end else begin
            frame_cnt_d = frame_cnt_q + 16'd1;
          end
        end
      end
      PAUSE: begin
        if (!bus.run) begin
          state_d     = IDLE;
          frame_cnt_d = '0;
        end else if (frame_tick) begin
          if (pause_cnt_q == PAUSE_LAST) begin
            state_d     = RUN;
            frame_cnt_d = '0;
          end else begin
            pause_cnt_d = pause_cnt_q + 16'd1;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge tft_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q      <= IDLE;
      v_d1_q       <= 1'b0;
      v_d2_q       <= 1'b0;
      frame_cnt_q  <= '0;
      pause_cnt_q  <= '0;
      pos_q        <= '0;
      dir_q        <= 2'b11;
      move_pulse_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      v_d1_q       <= bus.vsync;
      v_d2_q       <= v_d1_q;
      frame_cnt_q  <= frame_cnt_d;
      pause_cnt_q  <= pause_cnt_d;
      pos_q        <= pos_d;
      dir_q        <= dir_d;
      move_pulse_q <= move_pulse_d;
    end
  end

  assign bus.char_x0    = pos_q[0];
  assign bus.char_y0    = pos_q[1];
  assign bus.dir_x      = dir_q[0];
  assign bus.dir_y      = dir_q[1];
  assign bus.move_pulse = move_pulse_q;

  a_x_in_range: assert property (@(posedge tft_clk) disable iff (!sys_rst_n)
    {1'b0, pos_q[0]} <= X_MAX);
  a_y_in_range: assert property (@(posedge tft_clk) disable iff (!sys_rst_n)
    {1'b0, pos_q[1]} <= Y_MAX);
  a_pulse_single: assert property (@(posedge tft_clk) disable iff (!sys_rst_n)
    move_pulse_q |=> !move_pulse_q);

endmodule

// File: tb/tb_tft_char_mover.sv
// Scoreboard bench for tft_char_mover: default geometry plus a corner-bounce
// geometry (X_MAX = Y_MAX = 200) driven from one shared vsync.
module tb_tft_char_mover;

  typedef struct packed {
    logic [9:0] x;
    logic [9:0] y;
    logic       dx;
    logic       dy;
    int         fr;
  } exp_t;

`ifdef CHAR_MOVER_WRAP_EN
  localparam int LAST = 272;
`else
  localparam int LAST = 302;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic vsync = 1'b0;
  logic run1 = 1'b0;
  logic run2 = 1'b0;
  logic mp1_prev = 1'b0;
  logic mp2_prev = 1'b0;
  int   checks = 0;
  int   errors = 0;
  int   frame_no = 0;
  exp_t q1[$];
  exp_t q2[$];

  always #5 clk = ~clk;

  tft_char_mover_if bus1 ();
  tft_char_mover_if bus2 ();

  assign bus1.vsync = vsync;
  assign bus1.run   = run1;
  assign bus2.vsync = vsync;
  assign bus2.run   = run2;

  tft_char_mover dut1 (
    .tft_clk   (clk),
    .sys_rst_n (rst_n),
    .bus       (bus1)
  );

  tft_char_mover #(.CHAR_W(280), .CHAR_H(72)) dut2 (
    .tft_clk   (clk),
    .sys_rst_n (rst_n),
    .bus       (bus2)
  );

  // Hand-derived trajectory of the default geometry, one move every 2 frames.
  function automatic exp_t main_exp(input int m);
    exp_t e;
`ifdef CHAR_MOVER_WRAP_EN
    e.x  = 10'((2 * m) % 226);
    e.dx = 1'b1;
    if (m <= 120) begin
      e.y  = 10'(2 * m);
      e.dy = 1'(m < 120);
      e.fr = 2 * m;
    end else begin
      e.y  = 10'(240 - 2 * (m - 120));
      e.dy = 1'b0;
      e.fr = 272 + 2 * (m - 121);
    end
`else
    if (m <= 112) begin
      e.x = 10'(2 * m); e.y = 10'(2 * m);
      e.dx = 1'(m < 112); e.dy = 1'b1;
      e.fr = 2 * m;
    end else if (m <= 120) begin
      e.x = 10'(224 - 2 * (m - 112)); e.y = 10'(2 * m);
      e.dx = 1'b0; e.dy = 1'(m < 120);
      e.fr = 256 + 2 * (m - 113);
    end else begin
      e.x = 10'(224 - 2 * (m - 112)); e.y = 10'(240 - 2 * (m - 120));
      e.dx = 1'b0; e.dy = 1'b0;
      e.fr = 302 + 2 * (m - 121);
    end
`endif
    return e;
  endfunction

  // Corner geometry: both axes hit 200 on move 100, one 30-frame pause.
  function automatic exp_t corner_exp(input int m);
    exp_t e;
    if (m <= 100) begin
      e.x = 10'(2 * m); e.y = 10'(2 * m);
`ifdef CHAR_MOVER_WRAP_EN
      e.dx = 1'b1;
`else
      e.dx = 1'(m < 100);
`endif
      e.dy = 1'(m < 100);
      e.fr = 2 * m;
    end else begin
`ifdef CHAR_MOVER_WRAP_EN
      e.x = 10'd0; e.dx = 1'b1;
`else
      e.x = 10'd198; e.dx = 1'b0;
`endif
      e.y = 10'd198; e.dy = 1'b0;
      e.fr = 232;
    end
    return e;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end else begin
      $display("check %s: %0d", name, act);
    end
  endtask

  task automatic cmp_move(input string tag, input exp_t e, input logic [9:0] x,
                          input logic [9:0] y, input logic dx, input logic dy);
    checks++;
    if (x !== e.x || y !== e.y || dx !== e.dx || dy !== e.dy || frame_no != e.fr) begin
      errors++;
      $display("FAIL %s move: got x0=%0d y0=%0d dx=%0d dy=%0d frame=%0d, expected x0=%0d y0=%0d dx=%0d dy=%0d frame=%0d",
               tag, x, y, dx, dy, frame_no, e.x, e.y, e.dx, e.dy, e.fr);
    end else begin
      $display("%s move: frame=%0d x0=%0d y0=%0d dx=%0d dy=%0d", tag, frame_no, x, y, dx, dy);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && bus1.move_pulse) begin
      if (q1.size() == 0) begin
        checks++; errors++;
        $display("FAIL dut1 unexpected move_pulse: frame=%0d x0=%0d y0=%0d, expected none",
                 frame_no, bus1.char_x0, bus1.char_y0);
      end else begin
        cmp_move("dut1", q1.pop_front(), bus1.char_x0, bus1.char_y0, bus1.dir_x, bus1.dir_y);
      end
      if (mp1_prev) begin
        checks++; errors++;
        $display("FAIL dut1 pulse width: got 2+ cycles, expected 1");
      end
    end
    mp1_prev <= bus1.move_pulse;
  end

  always @(negedge clk) begin
    if (rst_n && bus2.move_pulse) begin
      if (q2.size() == 0) begin
        checks++; errors++;
        $display("FAIL dut2 unexpected move_pulse: frame=%0d x0=%0d y0=%0d, expected none",
                 frame_no, bus2.char_x0, bus2.char_y0);
      end else begin
        cmp_move("dut2", q2.pop_front(), bus2.char_x0, bus2.char_y0, bus2.dir_x, bus2.dir_y);
      end
      if (mp2_prev) begin
        checks++; errors++;
        $display("FAIL dut2 pulse width: got 2+ cycles, expected 1");
      end
    end
    mp2_prev <= bus2.move_pulse;
  end

  // One frame: vsync high for two cycles, optionally dropping run1 in the tick cycle.
  task automatic frame(input bit drop_run);
    @(negedge clk);
    vsync = 1'b1;
    frame_no++;
    @(negedge clk);
    if (drop_run) run1 = 1'b0;
    @(negedge clk);
    vsync = 1'b0;
    repeat (6) @(negedge clk);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, " x0"}, int'(bus1.char_x0), 0);
    chk({tag, " y0"}, int'(bus1.char_y0), 0);
    chk({tag, " dir_x"}, int'(bus1.dir_x), 1);
    chk({tag, " dir_y"}, int'(bus1.dir_y), 1);
    chk({tag, " move_pulse"}, int'(bus1.move_pulse), 0);
  endtask

  initial begin
    exp_t e;
    run1 = 1'b1;
    run2 = 1'b1;
    repeat (3) @(negedge clk);
    chk_reset_vals("reset");

    for (int m = 1; m <= 121; m++) q1.push_back(main_exp(m));
    for (int m = 1; m <= 101; m++) q2.push_back(corner_exp(m));

    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    for (int f = 1; f <= LAST; f++) begin
      frame(1'b0);
      if (f == 1) chk("after pulse 1 x0", int'(bus1.char_x0), 0);
      if (f == 2) chk("after pulse 2 x0", int'(bus1.char_x0), 2);
      if (f == 2) chk("after pulse 2 y0", int'(bus1.char_y0), 2);
      if (f == 3) chk("after pulse 3 x0", int'(bus1.char_x0), 2);
      if (f == 232) run2 = 1'b0;
    end

    // run falls in the cycle of a qualifying tick: no move, origin held.
    e = main_exp(121);
    frame(1'b0);
    frame(1'b1);
    chk("run drop x0 held", int'(bus1.char_x0), int'(e.x));
    chk("run drop y0 held", int'(bus1.char_y0), int'(e.y));
    frame(1'b0);
    frame(1'b0);
    chk("idle x0 held", int'(bus1.char_x0), int'(e.x));
    run1 = 1'b1;
    e = main_exp(122);
    e.fr = frame_no + 2;
    q1.push_back(e);
    frame(1'b0);
    frame(1'b0);

    // Asynchronous reset between clock edges.
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk_reset_vals("async reset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    e.x = 10'd2; e.y = 10'd2; e.dx = 1'b1; e.dy = 1'b1;
    e.fr = frame_no + 2;
    q1.push_back(e);
    frame(1'b0);
    frame(1'b0);
    repeat (4) @(negedge clk);

    chk("dut1 pending moves", q1.size(), 0);
    chk("dut2 pending moves", q2.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
